// File: rtl/do_cmd_sched.sv
// Timed command scheduler feeding the masked-write DO register stage.
// Optional output watchdog is built when DO_WDOG_EN is defined.
module do_cmd_sched #(
    parameter int                  WIDTH        = 32,
    parameter int                  DEPTH        = 8,
    parameter int                  DLY_W        = 16,
    parameter int                  WDOG_W       = 24,
    parameter logic [WDOG_W-1:0]   WDOG_TIMEOUT = 24'd1000000,
    parameter logic [WIDTH-1:0]    SAFE_VALUE   = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_data,
    input  logic [WIDTH-1:0]         cmd_mask,
    input  logic [DLY_W-1:0]         cmd_delay,
    input  logic                     flush,
    output logic [WIDTH-1:0]         do_wdata,
    output logic [WIDTH-1:0]         do_wmask,
    output logic                     do_we,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    input  logic                     wdog_arm,
    input  logic                     wdog_kick,
    input  logic                     wdog_clr,
    output logic                     wdog_trip
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

    state_t            state_q, state_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  pend_data_q, pend_data_d;
    logic [WIDTH-1:0]  pend_mask_q, pend_mask_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_we_q, do_we_d;
    logic [WIDTH-1:0]  do_wdata_q, do_wdata_d;
    logic [WIDTH-1:0]  do_wmask_q, do_wmask_d;

    logic [WIDTH-1:0]  mem_data_q [DEPTH];
    logic [WIDTH-1:0]  mem_mask_q [DEPTH];
    logic [DLY_W-1:0]  mem_dly_q  [DEPTH];

    logic full, empty, push, pop, wdog_fire, flush_all;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    // Valid/ready: a command transfers on any rising edge where cmd_valid and cmd_ready are both high.
    assign cmd_ready = rst_n & ~full & ~flush & ~wdog_trip;
    assign push      = cmd_valid & cmd_ready;
    assign flush_all = flush | wdog_fire;
    assign pop       = (state_q == S_IDLE) & ~empty & ~flush_all;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_data_d = pend_data_q;
        pend_mask_d = pend_mask_q;
        do_we_d     = 1'b0;
        do_wdata_d  = do_wdata_q;
        do_wmask_d  = do_wmask_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    pend_data_d = mem_data_q[rd_ptr_q];
                    pend_mask_d = mem_mask_q[rd_ptr_q];
                    cnt_d       = mem_dly_q[rd_ptr_q];
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DLY_W'(1);
                end else begin
                    state_d    = S_ISSUE;
                    do_we_d    = 1'b1;
                    do_wdata_d = pend_data_q;
                    do_wmask_d = pend_mask_q;
                end
            end
            S_ISSUE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A flush on the issuing edge cancels the strobe and keeps the held output values.
        if (flush_all) begin
            state_d    = S_IDLE;
            do_we_d    = 1'b0;
            do_wdata_d = do_wdata_q;
            do_wmask_d = do_wmask_q;
        end
        if (wdog_fire) begin
            do_we_d    = 1'b1;
            do_wdata_d = SAFE_VALUE;
            do_wmask_d = {WIDTH{1'b1}};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_all) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= cmd_data;
            mem_mask_q[wr_ptr_q] <= cmd_mask;
            mem_dly_q[wr_ptr_q]  <= cmd_delay;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_data_q <= '0;
            pend_mask_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            do_we_q     <= 1'b0;
            do_wdata_q  <= '0;
            do_wmask_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_data_q <= pend_data_d;
            pend_mask_q <= pend_mask_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            do_we_q     <= do_we_d;
            do_wdata_q  <= do_wdata_d;
            do_wmask_q  <= do_wmask_d;
        end
    end

    assign do_we      = do_we_q;
    assign do_wdata   = do_wdata_q;
    assign do_wmask   = do_wmask_q;
    assign fifo_count = count_q;
    assign busy       = ~empty | (state_q != S_IDLE);

`ifdef DO_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_trip_q, wdog_trip_d;

    // The trip fires on the edge where the counter would reach zero.
    always_comb begin
        wdog_cnt_d  = wdog_cnt_q;
        wdog_trip_d = wdog_trip_q;
        wdog_fire   = 1'b0;
        if (wdog_clr) begin
            wdog_cnt_d  = WDOG_TIMEOUT;
            wdog_trip_d = 1'b0;
        end else if (wdog_trip_q) begin
            wdog_cnt_d = wdog_cnt_q;
        end else if (!wdog_arm || wdog_kick) begin
            wdog_cnt_d = WDOG_TIMEOUT;
        end else begin
            wdog_cnt_d = wdog_cnt_q - WDOG_W'(1);
            if (wdog_cnt_q == WDOG_W'(1)) begin
                wdog_fire   = 1'b1;
                wdog_trip_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q  <= WDOG_TIMEOUT;
            wdog_trip_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    assign wdog_trip = wdog_trip_q;
`else
    logic wdog_unused;
    assign wdog_unused = wdog_arm ^ wdog_kick ^ wdog_clr;
    assign wdog_fire   = 1'b0;
    assign wdog_trip   = 1'b0;
`endif

endmodule

// File: tb/tb_do_cmd_sched.sv
// Directed bench for do_cmd_sched: per-cycle vector table plus multi-cycle sequences.
module tb_do_cmd_sched;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int DLY_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] cmd_mask;
  logic [DLY_W-1:0] cmd_delay;
  logic             flush;
  logic [WIDTH-1:0] do_wdata;
  logic [WIDTH-1:0] do_wmask;
  logic             do_we;
  logic [3:0]       fifo_count;
  logic             busy;
  logic             wdog_arm;
  logic             wdog_kick;
  logic             wdog_clr;
  logic             wdog_trip;

  do_cmd_sched #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DLY_W(DLY_W), .WDOG_W(24),
    .WDOG_TIMEOUT(24'd20), .SAFE_VALUE(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_delay(cmd_delay),
    .flush(flush),
    .do_wdata(do_wdata), .do_wmask(do_wmask), .do_we(do_we),
    .fifo_count(fifo_count), .busy(busy),
    .wdog_arm(wdog_arm), .wdog_kick(wdog_kick), .wdog_clr(wdog_clr),
    .wdog_trip(wdog_trip)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [31:0] m;
    logic [15:0] dl;
    logic        fl;
    logic        e_rdy;
    logic        e_we;
    logic [31:0] e_wd;
    logic [31:0] e_wm;
    logic [3:0]  e_cnt;
    logic        e_busy;
  } vec_t;

  vec_t tbl[64];
  int   n_tbl = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] d, input logic [31:0] m,
                     input logic [15:0] dl, input logic fl, input logic e_rdy,
                     input logic e_we, input logic [31:0] e_wd, input logic [31:0] e_wm,
                     input logic [3:0] e_cnt, input logic e_busy);
    tbl[n_tbl] = '{v, d, m, dl, fl, e_rdy, e_we, e_wd, e_wm, e_cnt, e_busy};
    n_tbl++;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] m,
                       input logic [15:0] dl);
    cmd_valid = v;
    cmd_data  = d;
    cmd_mask  = m;
    cmd_delay = dl;
  endtask

  // scoreboard: every strobe seen must match the head of exp_q
  task automatic tick();
    @(negedge clk);
    #1;
    if (do_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got data %h mask %h expected no strobe", do_wdata, do_wmask);
      end else begin
        chk("strobe", {do_wdata, do_wmask}, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0);
    flush = 1'b0;
    wdog_arm = 1'b0;
    wdog_kick = 1'b0;
    wdog_clr = 1'b0;

    // ---- table: single command, back-to-back ordering, flush on issuing edge
    add(1, 32'hFF, 32'hF, 16'd0, 0,  1, 0, 32'h0,  32'h0, 4'd0, 0);
    add(0, 0, 0, 0, 0,               1, 0, 32'h0,  32'h0, 4'd1, 1);
    add(0, 0, 0, 0, 0,               1, 0, 32'h0,  32'h0, 4'd0, 1);
    add(0, 0, 0, 0, 0,               1, 1, 32'hFF, 32'hF, 4'd0, 1);
    add(0, 0, 0, 0, 0,               1, 0, 32'hFF, 32'hF, 4'd0, 0);
    add(1, 32'hAA, 32'hF0, 16'd10, 0, 1, 0, 32'hFF, 32'hF, 4'd0, 0);
    add(1, 32'hBB, 32'h0F, 16'd0, 0,  1, 0, 32'hFF, 32'hF, 4'd1, 1);
    for (int i = 0; i < 11; i++)
      add(0, 0, 0, 0, 0,             1, 0, 32'hFF, 32'hF, 4'd1, 1);
    add(0, 0, 0, 0, 0,               1, 1, 32'hAA, 32'hF0, 4'd1, 1);
    add(0, 0, 0, 0, 0,               1, 0, 32'hAA, 32'hF0, 4'd1, 1);
    add(0, 0, 0, 0, 0,               1, 0, 32'hAA, 32'hF0, 4'd0, 1);
    add(0, 0, 0, 0, 0,               1, 1, 32'hBB, 32'h0F, 4'd0, 1);
    add(0, 0, 0, 0, 0,               1, 0, 32'hBB, 32'h0F, 4'd0, 0);
    add(1, 32'hCC, 32'hFF, 16'd3, 0,  1, 0, 32'hBB, 32'h0F, 4'd0, 0);
    add(0, 0, 0, 0, 0,               1, 0, 32'hBB, 32'h0F, 4'd1, 1);
    add(0, 0, 0, 0, 0,               1, 0, 32'hBB, 32'h0F, 4'd0, 1);
    add(0, 0, 0, 0, 0,               1, 0, 32'hBB, 32'h0F, 4'd0, 1);
    add(0, 0, 0, 0, 0,               1, 0, 32'hBB, 32'h0F, 4'd0, 1);
    add(1, 32'hEE, 32'hFF, 16'd0, 1,  0, 0, 32'hBB, 32'h0F, 4'd0, 1);
    add(0, 0, 0, 0, 0,               1, 0, 32'hBB, 32'h0F, 4'd0, 0);
    add(0, 0, 0, 0, 0,               1, 0, 32'hBB, 32'h0F, 4'd0, 0);

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_we", {63'd0, do_we}, 64'd0);
    chk("rst_wdata", {32'd0, do_wdata}, 64'd0);
    chk("rst_count", {60'd0, fifo_count}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_trip", {63'd0, wdog_trip}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < n_tbl; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].d, tbl[i].m, tbl[i].dl);
      flush = tbl[i].fl;
      #1;
      chk($sformatf("v%0d_ready", i), {63'd0, cmd_ready}, {63'd0, tbl[i].e_rdy});
      chk($sformatf("v%0d_we", i), {63'd0, do_we}, {63'd0, tbl[i].e_we});
      chk($sformatf("v%0d_wdata", i), {32'd0, do_wdata}, {32'd0, tbl[i].e_wd});
      chk($sformatf("v%0d_wmask", i), {32'd0, do_wmask}, {32'd0, tbl[i].e_wm});
      chk($sformatf("v%0d_count", i), {60'd0, fifo_count}, {60'd0, tbl[i].e_cnt});
      chk($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].e_busy});
    end
    drive(1'b0, '0, '0, '0);
    flush = 1'b0;
    tick();

    // ---- full FIFO: one pending plus DEPTH queued, extra push refused
    begin
      int guard;
      drive(1'b1, 32'h100, 32'hFFFF_FFFF, 16'd100);
      exp_q.push_back({32'h100, 32'hFFFF_FFFF});
      tick();
      for (int i = 0; i < DEPTH; i++) begin
        drive(1'b1, 32'h200 + 32'(i), 32'h0000_FFFF, 16'd100);
        exp_q.push_back({32'h200 + 32'(i), 32'h0000_FFFF});
        tick();
      end
      chk("full_count", {60'd0, fifo_count}, 64'd8);
      chk("full_ready", {63'd0, cmd_ready}, 64'd0);
      drive(1'b1, 32'hDEAD, 32'hFFFF_FFFF, 16'd0);
      repeat (3) tick();
      chk("full_extra_count", {60'd0, fifo_count}, 64'd8);
      drive(1'b0, '0, '0, '0);
      guard = 0;
      while (fifo_count == 4'd8 && guard < 300) begin
        tick();
        guard++;
      end
      chk("first_pop_count", {60'd0, fifo_count}, 64'd7);
      chk("first_pop_after_strobe", 64'(exp_q.size()), 64'd8);
      guard = 0;
      while (exp_q.size() != 0 && guard < 2000) begin
        tick();
        guard++;
      end
      chk("full_drain_left", 64'(exp_q.size()), 64'd0);
      repeat (300) tick();
      chk("full_end_busy", {63'd0, busy}, 64'd0);
      chk("full_end_count", {60'd0, fifo_count}, 64'd0);
    end

    // ---- flush while waiting with queued commands
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 32'hFF, 16'd20);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    repeat (5) tick();
    chk("pre_flush_count", {60'd0, fifo_count}, 64'd2);
    flush = 1'b1;
    #1;
    chk("flush_ready", {63'd0, cmd_ready}, 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_count", {60'd0, fifo_count}, 64'd0);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    repeat (60) tick();
    chk("flush_busy_late", {63'd0, busy}, 64'd0);

    // ---- asynchronous reset while waiting
    drive(1'b1, 32'h55, 32'hFF, 16'd30);
    tick();
    drive(1'b0, '0, '0, '0);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", {63'd0, do_we}, 64'd0);
    chk("arst_wdata", {32'd0, do_wdata}, 64'd0);
    chk("arst_wmask", {32'd0, do_wmask}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_ready", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) tick();
    chk("arst_after_busy", {63'd0, busy}, 64'd0);
    chk("arst_after_wdata", {32'd0, do_wdata}, 64'd0);

`ifdef DO_WDOG_EN
    // ---- watchdog trip with a pending and a queued command
    drive(1'b1, 32'h77, 32'hFF, 16'd100);
    tick();
    drive(1'b1, 32'h78, 32'hFF, 16'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    wdog_arm = 1'b1;
    repeat (19) tick();
    chk("wdog_pre_trip", {63'd0, wdog_trip}, 64'd0);
    exp_q.push_back({32'h0, 32'hFFFF_FFFF});
    tick();
    chk("wdog_trip", {63'd0, wdog_trip}, 64'd1);
    chk("wdog_safe_we", {63'd0, do_we}, 64'd1);
    chk("wdog_safe_left", 64'(exp_q.size()), 64'd0);
    chk("wdog_count", {60'd0, fifo_count}, 64'd0);
    chk("wdog_ready", {63'd0, cmd_ready}, 64'd0);
    drive(1'b1, 32'h99, 32'hFF, 16'd0);
    wdog_kick = 1'b1;
    repeat (3) tick();
    chk("wdog_push_refused", {60'd0, fifo_count}, 64'd0);
    chk("wdog_kick_ignored", {63'd0, wdog_trip}, 64'd1);
    drive(1'b0, '0, '0, '0);
    wdog_kick = 1'b0;
    repeat (150) tick();
    chk("wdog_dropped_busy", {63'd0, busy}, 64'd0);
    wdog_arm = 1'b0;
    wdog_clr = 1'b1;
    tick();
    wdog_clr = 1'b0;
    chk("wdog_clr_trip", {63'd0, wdog_trip}, 64'd0);
    chk("wdog_clr_ready", {63'd0, cmd_ready}, 64'd1);
`else
    wdog_arm = 1'b1;
    repeat (30) tick();
    chk("nowdog_trip", {63'd0, wdog_trip}, 64'd0);
    chk("nowdog_ready", {63'd0, cmd_ready}, 64'd1);
    wdog_arm = 1'b0;
`endif

    chk("final_exp_q", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
